snake_engine: RTL and testbench

Parametrised snake-game engine for the VGA snake project, successor to the fixed four-segment mover. It runs on the single system clock and advances on a one-cycle `tick` enable from the rate divider. It takes PS/2 keycodes with the key strobe and keeps a body of up to `MAX_LEN` segments in grid-cell coordinates. It detects wall and self collision, grows when the head reaches the food cell, and drives the renderer through a flattened body bus.

---
 rtl/snake_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// snake_engine: grid snake-game core driven by a one-cycle move tick.
// Keeps up to MAX_LEN body segments (segment 0 is the head), handles PS/2 key
// commands, wall and self collision, growth on food, and a saturating score.
// Build option: define SNAKE_WRAP_EN to make the walls wrap around instead of
// ending the game.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_EXIT     | screen blanked, body frozen (reset state)
// S_PLAY     | snake moves on every tick
// S_PAUSE    | body frozen, R resumes
// S_GAMEOVER | collision happened, body frozen until S or Esc

module snake_engine #(
    parameter int MAX_LEN   = 8,
    parameter int START_LEN = 4,
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int CW        = 6,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tick,
    input  logic [7:0]            keycode,
    input  logic                  newkeyStrobe,
    input  logic [CW-1:0]         food_x,
    input  logic [CW-1:0]         food_y,
    input  logic                  food_valid,
    output logic                  black,
    output logic                  game_over,
    output logic                  eat,
    output logic [LW-1:0]         length,
    output logic [7:0]            score,
    output logic [MAX_LEN*CW-1:0] body_x,
    output logic [MAX_LEN*CW-1:0] body_y
);

    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_UP    = 8'h43;
    localparam logic [7:0] KEY_DOWN  = 8'h42;
    localparam logic [7:0] KEY_LEFT  = 8'h3B;
    localparam logic [7:0] KEY_RIGHT = 8'h4B;

    localparam logic [CW-1:0] X_MAX     = CW'(GRID_W - 1);
    localparam logic [CW-1:0] Y_MAX     = CW'(GRID_H - 1);
    localparam logic [CW-1:0] START_Y   = CW'(GRID_H / 2);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] START_L   = LW'(START_LEN);

    typedef enum logic [1:0] {
        S_EXIT,
        S_PLAY,
        S_PAUSE,
        S_GAMEOVER
    } state_t;

    typedef enum logic [1:0] {
        D_RIGHT,
        D_LEFT,
        D_UP,
        D_DOWN
    } dir_t;

    state_t        state;
    dir_t          dir;
    dir_t          dir_pend;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];

    logic          k_s, k_esc, k_p, k_r, k_arrow;
    dir_t          k_dir;
    dir_t          ref_dir;
    logic          dir_wr;
    logic          move_try;
    logic          at_wall, wall_hit;
    logic [CW-1:0] nx, ny;
    logic          grow_hit, grow, self_hit, collide;
    logic [LW-1:0] chk_lim;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            D_RIGHT: return D_LEFT;
            D_LEFT:  return D_RIGHT;
            D_UP:    return D_DOWN;
            default: return D_UP;
        endcase
    endfunction

    // Restart column of segment i; indices past START_LEN are never rendered.
    function automatic logic [CW-1:0] start_x(input int i);
        return (i < START_LEN) ? CW'(START_LEN - 1 - i) : '0;
    endfunction

    // Key decode; keycode is only meaningful while the strobe is high.
    always_comb begin
        k_s     = newkeyStrobe && (keycode == KEY_S);
        k_esc   = newkeyStrobe && (keycode == KEY_ESC);
        k_p     = newkeyStrobe && (keycode == KEY_P);
        k_r     = newkeyStrobe && (keycode == KEY_R);
        k_arrow = 1'b1;
        k_dir   = D_RIGHT;
        case (keycode)
            KEY_UP:    k_dir = D_UP;
            KEY_DOWN:  k_dir = D_DOWN;
            KEY_LEFT:  k_dir = D_LEFT;
            KEY_RIGHT: k_dir = D_RIGHT;
            default:   k_arrow = 1'b0;
        endcase
        k_arrow = k_arrow && newkeyStrobe;
    end

    // A restart in the same cycle as a tick suppresses the move.
    assign move_try = tick && (state == S_PLAY) && !k_s;

    // When a tick commits the pending direction this cycle, a simultaneous
    // arrow key is judged against that newly committed direction.
    assign ref_dir = move_try ? dir_pend : dir;
    assign dir_wr  = k_arrow && (state == S_PLAY) && (k_dir != opposite(ref_dir));

    // Candidate head; the at-wall value doubles as the wrapped coordinate.
    always_comb begin
        at_wall = 1'b0;
        nx      = seg_x[0];
        ny      = seg_y[0];
        case (dir_pend)
            D_RIGHT: begin
                at_wall = (seg_x[0] == X_MAX);
                nx      = at_wall ? '0 : seg_x[0] + CW'(1);
            end
            D_LEFT: begin
                at_wall = (seg_x[0] == '0);
                nx      = at_wall ? X_MAX : seg_x[0] - CW'(1);
            end
            D_UP: begin
                at_wall = (seg_y[0] == '0);
                ny      = at_wall ? Y_MAX : seg_y[0] - CW'(1);
            end
            default: begin
                at_wall = (seg_y[0] == Y_MAX);
                ny      = at_wall ? '0 : seg_y[0] + CW'(1);
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_hit = 1'b0;
`else
    assign wall_hit = at_wall;
`endif

    // Growth and self collision; the tail is excluded unless the snake grows,
    // because a non-growing move vacates the tail cell.
    always_comb begin
        grow_hit = food_valid && (nx == food_x) && (ny == food_y);
        grow     = grow_hit && (length < MAX_LEN_L);
        chk_lim  = grow ? length : length - LW'(1);
        self_hit = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if ((LW'(j) < chk_lim) && (seg_x[j] == nx) && (seg_y[j] == ny)) begin
                self_hit = 1'b1;
            end
        end
        collide = wall_hit || self_hit;
    end

    // Flatten the segment registers onto the renderer buses.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
        assign body_x[g*CW +: CW] = seg_x[g];
        assign body_y[g*CW +: CW] = seg_y[g];
    end

    // Game FSM, direction registers, body shift and score.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_EXIT;
            black     <= 1'b1;
            game_over <= 1'b0;
            eat       <= 1'b0;
            score     <= 8'd0;
            length    <= START_L;
            dir       <= D_RIGHT;
            dir_pend  <= D_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= start_x(i);
                seg_y[i] <= START_Y;
            end
        end else begin
            eat <= 1'b0;

            if (k_s) begin
                state     <= S_PLAY;
                black     <= 1'b0;
                game_over <= 1'b0;
            end else if (k_esc) begin
                state     <= S_EXIT;
                black     <= 1'b1;
                game_over <= 1'b0;
            end else if (move_try && collide) begin
                state     <= S_GAMEOVER;
                game_over <= 1'b1;
            end else if ((state == S_PLAY) && k_p) begin
                state <= S_PAUSE;
            end else if ((state == S_PAUSE) && k_r) begin
                state <= S_PLAY;
            end

            if (k_s) begin
                score    <= 8'd0;
                length   <= START_L;
                dir      <= D_RIGHT;
                dir_pend <= D_RIGHT;
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= start_x(i);
                    seg_y[i] <= START_Y;
                end
            end else begin
                if (move_try) begin
                    dir <= dir_pend;
                end
                if (dir_wr) begin
                    dir_pend <= k_dir;
                end
                if (move_try && !collide) begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= nx;
                    seg_y[0] <= ny;
                    if (grow) begin
                        length <= length + LW'(1);
                    end
                    if (grow_hit) begin
                        eat <= 1'b1;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Directed-vector bench for snake_engine with default parameters
// (8 segments, start length 4, 64x48 grid).

module tb_snake_engine;

    localparam logic [7:0] K_ESC = 8'h76;
    localparam logic [7:0] K_S   = 8'h1B;
    localparam logic [7:0] K_P   = 8'h4D;
    localparam logic [7:0] K_R   = 8'h2D;
    localparam logic [7:0] K_UP  = 8'h43;
    localparam logic [7:0] K_DN  = 8'h42;
    localparam logic [7:0] K_LT  = 8'h3B;
    localparam logic [7:0] K_RT  = 8'h4B;

    logic        CLK = 1'b0;
    logic        RST;
    logic        tick;
    logic [7:0]  keycode;
    logic        newkeyStrobe;
    logic [5:0]  food_x, food_y;
    logic        food_valid;
    logic        black, game_over, eat;
    logic [3:0]  length;
    logic [7:0]  score;
    logic [47:0] body_x, body_y;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       tk;
        logic       st;
        logic [7:0] kc;
        logic       fv;
        logic [5:0] fx;
        logic [5:0] fy;
        int hx, hy, s1x, s1y, ln, blk, go, et, sc;
    } vec_t;

    vec_t vt[$];

    snake_engine dut (
        .CLK          (CLK),
        .RST          (RST),
        .tick         (tick),
        .keycode      (keycode),
        .newkeyStrobe (newkeyStrobe),
        .food_x       (food_x),
        .food_y       (food_y),
        .food_valid   (food_valid),
        .black        (black),
        .game_over    (game_over),
        .eat          (eat),
        .length       (length),
        .score        (score),
        .body_x       (body_x),
        .body_y       (body_y)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int hx, input int hy, input int s1x,
                             input int s1y, input int ln, input int blk, input int go,
                             input int et, input int sc);
        chk({tag, " head_x"}, int'(body_x[5:0]), hx);
        chk({tag, " head_y"}, int'(body_y[5:0]), hy);
        chk({tag, " seg1_x"}, int'(body_x[11:6]), s1x);
        chk({tag, " seg1_y"}, int'(body_y[11:6]), s1y);
        chk({tag, " length"}, int'(length), ln);
        chk({tag, " black"}, int'(black), blk);
        chk({tag, " game_over"}, int'(game_over), go);
        chk({tag, " eat"}, int'(eat), et);
        chk({tag, " score"}, int'(score), sc);
    endtask

    task automatic step(input logic tk, input logic st, input logic [7:0] kc,
                        input logic fv, input logic [5:0] fx, input logic [5:0] fy);
        tick = tk; newkeyStrobe = st; keycode = kc;
        food_valid = fv; food_x = fx; food_y = fy;
        @(posedge CLK);
        #1;
        tick = 1'b0; newkeyStrobe = 1'b0; keycode = 8'h00;
        food_valid = 1'b0; food_x = '0; food_y = '0;
    endtask

    task automatic add(input logic tk, input logic st, input logic [7:0] kc, input logic fv,
                       input logic [5:0] fx, input logic [5:0] fy, input int hx, input int hy,
                       input int s1x, input int s1y, input int ln, input int blk,
                       input int go, input int et, input int sc);
        vec_t v;
        v.tk = tk; v.st = st; v.kc = kc; v.fv = fv; v.fx = fx; v.fy = fy;
        v.hx = hx; v.hy = hy; v.s1x = s1x; v.s1y = s1y; v.ln = ln;
        v.blk = blk; v.go = go; v.et = et; v.sc = sc;
        vt.push_back(v);
    endtask

    initial begin
        //   tk st key   fv fx fy   hx hy s1x s1y ln blk go eat sc
        add(1, 0, 8'h00, 0, 0, 0,  3, 24, 2, 24, 4, 1, 0, 0, 0); // tick in EXIT ignored
        add(0, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  4, 24, 3, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  5, 24, 4, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  6, 24, 5, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_DN,  0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  3, 25, 3, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_LT,  0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0); // reversal ignored
        add(1, 0, 8'h00, 0, 0, 0,  4, 24, 3, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 1, 4, 24, 4, 24, 3, 24, 5, 0, 0, 1, 1); // grow
        add(0, 0, 8'h00, 0, 0, 0,  4, 24, 3, 24, 5, 0, 0, 0, 1); // eat one cycle only
        add(0, 1, K_UP,  0, 0, 0,  4, 24, 3, 24, 5, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0, 0, 0,  4, 23, 4, 24, 5, 0, 0, 0, 1);
        add(0, 1, K_LT,  0, 0, 0,  4, 23, 4, 24, 5, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0, 0, 0,  3, 23, 4, 23, 5, 0, 0, 0, 1);
        add(0, 1, K_DN,  0, 0, 0,  3, 23, 4, 23, 5, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0, 0, 0,  3, 23, 4, 23, 5, 0, 1, 0, 1); // hits segment 3
        add(1, 0, 8'h00, 0, 0, 0,  3, 23, 4, 23, 5, 0, 1, 0, 1);
        add(0, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_P,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 8'h00, 0, 0, 0, 3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_R,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  4, 24, 3, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_ESC, 0, 0, 0,  4, 24, 3, 24, 4, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  4, 24, 3, 24, 4, 1, 0, 0, 0);
        add(1, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0); // restart beats tick
        add(1, 1, K_P,   0, 0, 0,  4, 24, 3, 24, 4, 0, 0, 0, 0); // move then pause
        add(1, 0, 8'h00, 0, 0, 0,  4, 24, 3, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_R,   0, 0, 0,  4, 24, 3, 24, 4, 0, 0, 0, 0);
        add(1, 1, K_DN,  0, 0, 0,  5, 24, 4, 24, 4, 0, 0, 0, 0); // key applies next tick
        add(1, 0, 8'h00, 0, 0, 0,  5, 25, 5, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_S,   0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_UP,  0, 0, 0,  3, 24, 2, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  3, 23, 3, 24, 4, 0, 0, 0, 0);
        add(0, 1, K_LT,  0, 0, 0,  3, 23, 3, 24, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  2, 23, 3, 23, 4, 0, 0, 0, 0);
        add(0, 1, K_DN,  0, 0, 0,  2, 23, 3, 23, 4, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,  2, 24, 2, 23, 4, 0, 0, 0, 0); // into vacating tail
        add(0, 1, K_UP,  0, 0, 0,  2, 24, 2, 23, 4, 0, 0, 0, 0); // reversal ignored
        add(1, 0, 8'h00, 0, 0, 0,  2, 25, 2, 24, 4, 0, 0, 0, 0);

        RST = 1'b1; tick = 1'b0; newkeyStrobe = 1'b0; keycode = 8'h00;
        food_valid = 1'b0; food_x = '0; food_y = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_all("reset", 3, 24, 2, 24, 4, 1, 0, 0, 0);
        chk("reset seg3_x", int'(body_x[23:18]), 0);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].tk, vt[i].st, vt[i].kc, vt[i].fv, vt[i].fx, vt[i].fy);
            check_all($sformatf("vec%0d", i), vt[i].hx, vt[i].hy, vt[i].s1x, vt[i].s1y,
                      vt[i].ln, vt[i].blk, vt[i].go, vt[i].et, vt[i].sc);
        end

        // Grow to capacity, then eat once more at full length.
        step(0, 1, K_S, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 8'h00, 1, 6'(4 + k), 6'd24);
            chk($sformatf("cap%0d head_x", k), int'(body_x[5:0]), 4 + k);
            chk($sformatf("cap%0d eat", k), int'(eat), 1);
            chk($sformatf("cap%0d length", k), int'(length), (5 + k > 8) ? 8 : 5 + k);
            chk($sformatf("cap%0d score", k), int'(score), k + 1);
        end
        chk("cap tail_x", int'(body_x[47:42]), 1);
        chk("cap tail_y", int'(body_y[47:42]), 24);

        // Run into the right wall.
        step(0, 1, K_S, 0, 0, 0);
        repeat (60) step(1, 0, 8'h00, 0, 0, 0);
        chk("edge head_x", int'(body_x[5:0]), 63);
        chk("edge game_over", int'(game_over), 0);
        step(1, 0, 8'h00, 0, 0, 0);
`ifdef SNAKE_WRAP_EN
        chk("wall head_x", int'(body_x[5:0]), 0);
        chk("wall game_over", int'(game_over), 0);
`else
        chk("wall head_x", int'(body_x[5:0]), 63);
        chk("wall game_over", int'(game_over), 1);
`endif
        chk("wall head_y", int'(body_y[5:0]), 24);

        // Reset wins over a tick in the same cycle.
        step(0, 1, K_S, 0, 0, 0);
        step(1, 0, 8'h00, 1, 4, 24);
        chk("pre_rst score", int'(score), 1);
        RST = 1'b1;
        step(1, 0, 8'h00, 0, 0, 0);
        RST = 1'b0;
        check_all("rst_tick", 3, 24, 2, 24, 4, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
